// File: rtl/hf_xcorr_pkg.sv
// Shared types and helpers for the HF I/Q cross-correlator and its SSP transmitter.
package hf_xcorr_pkg;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  // Window length exponent: half-period, times two, times cycles per window.
  function automatic int calc_log2n(input int half_log2, input int cyc_log2);
    return half_log2 + 1 + cyc_log2;
  endfunction

  // Accumulator width large enough for N full-scale samples of either sign.
  function automatic int calc_acc_w(input int adc_w, input int log2n);
    return adc_w + log2n + 1;
  endfunction

  // Serial word carries I then Q.
  function automatic int calc_word_w(input int out_w);
    return 2 * out_w;
  endfunction

  // Square-wave reference: negative while the half-period bit of the phase is set.
  function automatic logic ref_neg(input logic [31:0] phase, input int half_log2);
    return ((phase >> half_log2) & 32'd1) != 32'd0;
  endfunction

  // Saturate a signed value into the signed range of out_w bits.
  function automatic logic signed [31:0] sat(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (v > hi) begin
      return 32'(hi);
    end else if (v < lo) begin
      return 32'(lo);
    end
    return 32'(v);
  endfunction

endpackage

// File: rtl/hf_xcorr_ssp_master_tx.sv
// SSP master transmitter: pops a word via valid/ready, shifts it out MSB-first
// with a divided serial clock, and flags the first bit period with ssp_frame.
module hf_xcorr_ssp_master_tx
  import hf_xcorr_pkg::*;
#(
  parameter int WORD_W  = 16,
  parameter int SCK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_valid,
  input  logic [WORD_W-1:0] data,
  output logic              data_ready,
  output logic              ssp_clk,
  output logic              ssp_frame,
  output logic              ssp_din
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  tx_state_t         state_reg, state_next;
  logic              sck_reg, sck_next;
  logic              frame_reg, frame_next;
  logic [WORD_W-1:0] shreg_reg, shreg_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;

  // State register; reset forces the serial lines low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= TX_IDLE;
      sck_reg   <= 1'b0;
      frame_reg <= 1'b0;
      shreg_reg <= '0;
      div_reg   <= '0;
      bit_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sck_reg   <= sck_next;
      frame_reg <= frame_next;
      shreg_reg <= shreg_next;
      div_reg   <= div_next;
      bit_reg   <= bit_next;
    end
  end

  // Bit period is SCK_DIV low then SCK_DIV high; data moves only at the falling edge,
  // where the next word may be taken directly so words run back to back.
  always_comb begin
    state_next = state_reg;
    sck_next   = sck_reg;
    frame_next = frame_reg;
    shreg_next = shreg_reg;
    div_next   = div_reg;
    bit_next   = bit_reg;
    data_ready = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          state_next = TX_SHIFT;
          shreg_next = data;
          frame_next = 1'b1;
          sck_next   = 1'b0;
          div_next   = '0;
          bit_next   = '0;
        end
      end
      TX_SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (!sck_reg) begin
            sck_next = 1'b1;
          end else begin
            sck_next   = 1'b0;
            frame_next = 1'b0;
            if (bit_reg == BIT_LAST) begin
              data_ready = 1'b1;
              bit_next   = '0;
              if (data_valid) begin
                shreg_next = data;
                frame_next = 1'b1;
              end else begin
                state_next = TX_IDLE;
                shreg_next = '0;
              end
            end else begin
              bit_next   = bit_reg + BIT_W'(1);
              shreg_next = {shreg_reg[WORD_W-2:0], 1'b0};
            end
          end
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign ssp_clk   = sck_reg;
  assign ssp_frame = frame_reg;
  assign ssp_din   = shreg_reg[WORD_W-1];

endmodule

// File: rtl/hf_xcorr_ssp_master.sv
// HF reader-mode BPSK I/Q correlator: phase counters, I/Q accumulators, AM hysteresis,
// result FIFO, feeding an SSP master transmitter. Single clock, sample_en paced.
module hf_xcorr_ssp_master
  import hf_xcorr_pkg::*;
#(
  parameter int ADC_W      = 8,
  parameter int HALF_LOG2  = 3,
  parameter int CYC_LOG2   = 2,
  parameter int OUT_W      = 8,
  parameter int OUT_SHIFT  = 6,
  parameter int SCK_DIV    = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int HYST_TMO   = 4095
) (
  input  logic             ck_1356meg,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sample_en,
  input  logic [ADC_W-1:0] adc_d,
  input  logic             snoop,
  input  logic             ovr_clr,
  output logic             ssp_clk,
  output logic             ssp_frame,
  output logic             ssp_din,
  output logic             overrun,
  output logic             hyst,
  output logic             win_done
);

  localparam int LOG2N  = calc_log2n(HALF_LOG2, CYC_LOG2);
  localparam int ACC_W  = calc_acc_w(ADC_W, LOG2N);
  localparam int WORD_W = calc_word_w(OUT_W);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LOW_W  = $clog2(HYST_TMO + 1);
  localparam logic [LOG2N-1:0] CNT_LAST  = '1;
  localparam logic [LOG2N-1:0] CNT_MID   = LOG2N'((1 << (LOG2N - 1)) - 1);
  localparam logic [LOG2N-1:0] QCNT_INIT = LOG2N'(1 << (HALF_LOG2 - 1));
  localparam logic [LOW_W-1:0] LOW_LAST  = LOW_W'(HYST_TMO - 1);
  localparam logic [PTR_W:0]   PTR_ONE   = 1;
  localparam logic [PTR_W:0]   FULL_XOR  = {1'b1, {PTR_W{1'b0}}};

  logic [LOG2N-1:0]        cnt_reg, qcnt_reg;
  logic signed [ACC_W-1:0] acc_i_reg, acc_q_reg;
  logic                    hyst_reg, snap_i_reg;
  logic [LOW_W-1:0]        low_reg;
  logic                    push_reg, overrun_reg;
  logic [WORD_W-1:0]       word_reg;
  logic [WORD_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr_reg, rd_ptr_reg;

  logic signed [ACC_W-1:0] adc_ext, acc_i_sum, acc_q_sum, i_shift, q_shift;
  logic signed [63:0]      i_wide, q_wide;
  logic [OUT_W-1:0]        i_res, q_res;
  logic                    win_end, hyst_after;
  logic                    fifo_full, fifo_empty, pop, push_ok, tx_ready;

  // Correlate the current sample and form the saturated result for a window end.
  always_comb begin
    adc_ext   = ACC_W'($signed({1'b0, adc_d}));
    acc_i_sum = ref_neg(32'(cnt_reg), HALF_LOG2) ? acc_i_reg - adc_ext : acc_i_reg + adc_ext;
    acc_q_sum = ref_neg(32'(qcnt_reg), HALF_LOG2) ? acc_q_reg - adc_ext : acc_q_reg + adc_ext;
    i_shift   = acc_i_sum >>> OUT_SHIFT;
    q_shift   = acc_q_sum >>> OUT_SHIFT;
    i_wide    = 64'(i_shift);
    q_wide    = 64'(q_shift);
    i_res     = OUT_W'(sat(i_wide, OUT_W));
    q_res     = OUT_W'(sat(q_wide, OUT_W));
    if (snoop) begin
      i_res[0] = snap_i_reg;
      q_res[0] = hyst_reg;
    end
    win_end = sample_en && enable && (cnt_reg == CNT_LAST);
  end

  // Phase counters and accumulators; held at their start values while disabled.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      qcnt_reg   <= QCNT_INIT;
      acc_i_reg  <= '0;
      acc_q_reg  <= '0;
      snap_i_reg <= 1'b0;
    end else if (!enable) begin
      cnt_reg   <= '0;
      qcnt_reg  <= QCNT_INIT;
      acc_i_reg <= '0;
      acc_q_reg <= '0;
    end else if (sample_en) begin
      if (cnt_reg == CNT_MID) begin
        snap_i_reg <= hyst_reg;
      end
      if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        qcnt_reg  <= QCNT_INIT;
        acc_i_reg <= '0;
        acc_q_reg <= '0;
      end else begin
        cnt_reg   <= cnt_reg + LOG2N'(1);
        qcnt_reg  <= qcnt_reg + LOG2N'(1);
        acc_i_reg <= acc_i_sum;
        acc_q_reg <= acc_q_sum;
      end
    end
  end

  // Register the window result; its valid strobe doubles as win_done and the FIFO push.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      push_reg <= 1'b0;
      word_reg <= '0;
    end else begin
      push_reg <= win_end;
      if (win_end) begin
        word_reg <= {i_res, q_res};
      end
    end
  end

  // Rail samples set the AM state directly; a long run of low state times out to high.
  always_comb begin
    hyst_after = hyst_reg;
    if (&adc_d) begin
      hyst_after = 1'b1;
    end else if (~|adc_d) begin
      hyst_after = 1'b0;
    end
  end

  // Hysteresis state and its low-time counter.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      hyst_reg <= 1'b0;
      low_reg  <= '0;
    end else if (sample_en) begin
      if (hyst_after) begin
        hyst_reg <= 1'b1;
        low_reg  <= '0;
      end else if (low_reg == LOW_LAST) begin
        hyst_reg <= 1'b1;
        low_reg  <= '0;
      end else begin
        hyst_reg <= 1'b0;
        low_reg  <= low_reg + LOW_W'(1);
      end
    end
  end

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = ((wr_ptr_reg ^ rd_ptr_reg) == FULL_XOR);
  assign pop        = tx_ready && !fifo_empty;
  assign push_ok    = push_reg && (!fifo_full || pop);

  // FIFO pointers and the sticky overrun flag (a drop beats a same-cycle clear).
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push_reg && !push_ok) begin
        overrun_reg <= 1'b1;
      end else if (ovr_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are meaningful only between the pointers.
  always_ff @(posedge ck_1356meg) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= word_reg;
    end
  end

  hf_xcorr_ssp_master_tx #(
    .WORD_W  (WORD_W),
    .SCK_DIV (SCK_DIV)
  ) u_tx (
    .clk        (ck_1356meg),
    .rst_n      (rst_n),
    .data_valid (!fifo_empty),
    .data       (fifo_mem[rd_ptr_reg[PTR_W-1:0]]),
    .data_ready (tx_ready),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din)
  );

  assign overrun  = overrun_reg;
  assign hyst     = hyst_reg;
  assign win_done = push_reg;

endmodule

// File: tb/tb_hf_xcorr_ssp_master.sv
// Directed bench: a sample-level reference model queues expected words, serial monitors
// deserialise both instances (default and slow-clock) and compare in order.
module tb_hf_xcorr_ssp_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] adc_d = 8'd0;
  logic       snoop = 1'b0;
  logic       ovr_clr = 1'b0;

  logic ssp_clk, ssp_frame, ssp_din, overrun, hyst, win_done;
  logic s8_clk, s8_frame, s8_din, s8_overrun, s8_hyst, s8_win_done;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q [$];
  logic [15:0] exp8_q [$];
  logic        track8 = 1'b0;
  int          mon_bidx = 0;

  // reference model state
  int   m_cnt, m_qcnt, m_acc_i, m_acc_q, m_low;
  logic m_hyst, m_snap;

  always #5 clk = ~clk;

  hf_xcorr_ssp_master dut (
    .ck_1356meg (clk), .rst_n (rst_n), .enable (enable), .sample_en (sample_en),
    .adc_d (adc_d), .snoop (snoop), .ovr_clr (ovr_clr),
    .ssp_clk (ssp_clk), .ssp_frame (ssp_frame), .ssp_din (ssp_din),
    .overrun (overrun), .hyst (hyst), .win_done (win_done)
  );

  hf_xcorr_ssp_master #(.SCK_DIV(8)) dut8 (
    .ck_1356meg (clk), .rst_n (rst_n), .enable (enable), .sample_en (sample_en),
    .adc_d (adc_d), .snoop (snoop), .ovr_clr (ovr_clr),
    .ssp_clk (s8_clk), .ssp_frame (s8_frame), .ssp_din (s8_din),
    .overrun (s8_overrun), .hyst (s8_hyst), .win_done (s8_win_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_qcnt = 4; m_acc_i = 0; m_acc_q = 0; m_low = 0;
    m_hyst = 1'b0; m_snap = 1'b0;
  endtask

  task automatic model_sample(input logic [7:0] d, output logic wd);
    int dv;
    int iv;
    int qv;
    logic [15:0] w;
    dv = int'(d);
    wd = 1'b0;
    if (enable) begin
      if (m_cnt == 31) m_snap = m_hyst;
      if ((m_cnt % 16) < 8) m_acc_i += dv; else m_acc_i -= dv;
      if ((m_qcnt % 16) < 8) m_acc_q += dv; else m_acc_q -= dv;
      if (m_cnt == 63) begin
        iv = sat8(m_acc_i >>> 6);
        qv = sat8(m_acc_q >>> 6);
        w = {iv[7:0], qv[7:0]};
        if (snoop) begin
          w[8] = m_snap;
          w[0] = m_hyst;
        end
        exp_q.push_back(w);
        if (track8) exp8_q.push_back(w);
        wd = 1'b1;
        m_cnt = 0; m_qcnt = 4; m_acc_i = 0; m_acc_q = 0;
      end else begin
        m_cnt++;
        m_qcnt = (m_qcnt + 1) % 64;
      end
    end else begin
      m_cnt = 0; m_qcnt = 4; m_acc_i = 0; m_acc_q = 0;
    end
    if (d == 8'hFF) begin
      m_hyst = 1'b1; m_low = 0;
    end else begin
      if (d == 8'h00) m_hyst = 1'b0;
      if (!m_hyst) begin
        m_low++;
        if (m_low == 4095) begin m_hyst = 1'b1; m_low = 0; end
      end else begin
        m_low = 0;
      end
    end
  endtask

  task automatic do_sample(input logic [7:0] d, input int gap);
    logic wd_exp;
    adc_d = d;
    sample_en = 1'b1;
    model_sample(d, wd_exp);
    @(negedge clk);
    sample_en = 1'b0;
    chk("win_done", 32'(win_done), 32'(wd_exp));
    chk("hyst", 32'(hyst), 32'(m_hyst));
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk("win_done_idle", 32'(win_done), 32'd0);
    end
  endtask

  // one window: value v on phases 0-7 of each 16-sample subcarrier cycle, 0 elsewhere
  task automatic square_window(input logic [7:0] v, input int gap);
    for (int s = 0; s < 64; s++) do_sample(((s % 16) < 8) ? v : 8'd0, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    exp8_q.delete();
    #1;
    chk("rst_ssp_clk", 32'(ssp_clk), 32'd0);
    chk("rst_ssp_frame", 32'(ssp_frame), 32'd0);
    chk("rst_ssp_din", 32'(ssp_din), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_hyst", 32'(hyst), 32'd0);
    chk("rst_win_done", 32'(win_done), 32'd0);
    chk("rst_s8_clk", 32'(s8_clk), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_words", 32'(exp_q.size()), 32'd0);
    chk("drain_words_s8", 32'(exp8_q.size()), 32'd0);
    chk("overrun_clear", 32'(overrun), 32'd0);
  endtask

  // Serial monitor for the default instance.
  initial begin
    logic        prev;
    logic [15:0] sh;
    logic [15:0] e;
    prev = 1'b0; sh = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0; mon_bidx = 0; sh = '0;
      end else begin
        if (ssp_clk && !prev) begin
          chk("frame", 32'(ssp_frame), 32'(mon_bidx == 0));
          sh = {sh[14:0], ssp_din};
          if (mon_bidx == 15) begin
            mon_bidx = 0;
            chk("word_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("word", 32'(sh), 32'(e));
            end
          end else begin
            mon_bidx++;
          end
        end
        prev = ssp_clk;
      end
    end
  end

  // Serial monitor for the slow-clock instance; compares only while tracked.
  initial begin
    logic        prev;
    logic [15:0] sh;
    logic [15:0] e;
    int          bidx;
    prev = 1'b0; sh = '0; bidx = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0; bidx = 0; sh = '0;
      end else begin
        if (s8_clk && !prev) begin
          if (track8) chk("s8_frame", 32'(s8_frame), 32'(bidx == 0));
          sh = {sh[14:0], s8_din};
          if (bidx == 15) begin
            bidx = 0;
            if (track8) begin
              chk("s8_word_expected", 32'(exp8_q.size() > 0), 32'd1);
              if (exp8_q.size() > 0) begin
                e = exp8_q.pop_front();
                chk("s8_word", 32'(sh), 32'(e));
              end
            end
          end else begin
            bidx++;
          end
        end
        prev = s8_clk;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();

    // 1: square wave in phase with I -> 0x7F00, twice
    do_reset();
    enable = 1'b1;
    square_window(8'd255, 1);
    square_window(8'd255, 1);
    drain(400);

    // 2: constant mid-scale -> zero I/Q; disabled stretch pushes nothing
    do_reset();
    for (int s = 0; s < 128; s++) do_sample(8'd128, 2);
    for (int s = 0; s < 10; s++) do_sample(8'd200, 1);
    enable = 1'b0;
    for (int s = 0; s < 10; s++) do_sample(8'd200, 1);
    enable = 1'b1;
    for (int s = 0; s < 64; s++) do_sample(8'(s * 3), 1);
    drain(400);

    // 3: sample_en held low mid-window
    do_reset();
    for (int s = 0; s < 20; s++) do_sample(8'(255 - s * 7), 1);
    repeat (40) begin
      @(negedge clk);
      chk("win_done_frozen", 32'(win_done), 32'd0);
    end
    for (int s = 20; s < 64; s++) do_sample(8'(255 - s * 7), 1);
    drain(400);

    // 5: snoop, 4095 zero samples force hyst high
    do_reset();
    snoop = 1'b1;
    for (int s = 0; s < 4094; s++) do_sample(8'd0, 1);
    chk("hyst_before_tmo", 32'(hyst), 32'd0);
    do_sample(8'd0, 1);
    chk("hyst_at_tmo", 32'(hyst), 32'd1);
    do_sample(8'd0, 1);
    drain(400);
    snoop = 1'b0;

    // 6: reset mid-word, then a fresh window
    do_reset();
    square_window(8'd255, 1);
    for (int s = 0; s < 16; s++) do_sample(8'd255, 1);
    n = 0;
    while (mon_bidx < 4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("mid_word_reached", 32'(mon_bidx >= 4), 32'd1);
    do_reset();
    square_window(8'd255, 1);
    drain(400);

    // 4: slow serial clock overflows the FIFO; the fourth result is lost
    do_reset();
    track8 = 1'b1;
    square_window(8'd255, 0);
    square_window(8'd200, 0);
    square_window(8'd100, 0);
    square_window(8'd50, 0);
    @(negedge clk);
    chk("s8_overrun_set", 32'(s8_overrun), 32'd1);
    chk("overrun_fast_clear", 32'(overrun), 32'd0);
    void'(exp8_q.pop_back());
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("s8_overrun_cleared", 32'(s8_overrun), 32'd0);
    drain(3000);
    track8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
